// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift/rotate engine for the 8-bit ALU path. An operand, shift
// amount and operation are captured when START is accepted. The working copy
// of the operand then moves one bit position per clock. When the count runs
// out, RESULT is loaded and DONE pulses for one cycle. The control unit
// stalls while BUSY is high.
//
// Ports:
//   CLK        rising-edge system clock
//   RESET      asynchronous, active-high reset
//   START      request, accepted in IDLE or DONE state
//   DATA_IN    operand, captured with START
//   SHIFT_AMT  shift amount, captured with START
//   SHIFT_OP   00 sll, 01 srl, 10 sra, 11 ror, captured with START
//   BUSY       high while an accepted operation is in progress
//   DONE       one-cycle pulse marking RESULT valid
//   RESULT     shifted value, held until the next START is accepted
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH     = 8,
    parameter int AMT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [WIDTH-1:0]     DATA_IN,
    input  logic [AMT_WIDTH-1:0] SHIFT_AMT,
    input  logic [1:0]           SHIFT_OP,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [WIDTH-1:0]     RESULT
);

    // The counter only ever needs to hold values 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] work;
    logic [1:0]       op;
    logic [WIDTH-1:0] work_step;
    logic [CW-1:0]    eff_count;
    logic [31:0]      amt_ext;
    logic [31:0]      amt_clamped;
    logic [31:0]      amt_mod;
    logic             accept;

    // START is accepted in IDLE and in DONE. This allows back-to-back work
    // without an extra idle cycle between operations.
    assign accept = START && ((state == ST_IDLE) || (state == ST_DONE));

    // Compute the effective step count at acceptance time. Plain shifts
    // saturate at WIDTH, because further steps could not change an all-fill
    // value. Rotates repeat every WIDTH steps, so the amount is reduced
    // modulo WIDTH.
    always_comb begin
        amt_ext     = 32'(SHIFT_AMT);
        amt_clamped = (amt_ext >= 32'(WIDTH)) ? 32'(WIDTH) : amt_ext;
        amt_mod     = amt_ext % 32'(WIDTH);
        eff_count   = (SHIFT_OP == OP_ROR) ? CW'(amt_mod) : CW'(amt_clamped);
    end

    // Perform one bit-position move of the working register. The sra fill
    // bit is taken from the current MSB, so the sign is carried at each step.
    always_comb begin
        work_step = work;
        case (op)
            OP_SLL:  work_step = {work[WIDTH-2:0], 1'b0};
            OP_SRL:  work_step = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  work_step = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_ROR:  work_step = {work[0], work[WIDTH-1:1]};
            default: work_step = work;
        endcase
    end

    // Hold the state register. Reset aborts any operation immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Select the next state. A zero count still spends one cycle in SHIFT,
    // so BUSY covers the accepting cycle before DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (START) state_next = ST_SHIFT;
            ST_SHIFT: if (count == '0) state_next = ST_DONE;
            ST_DONE:  state_next = START ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on acceptance, then step once per clock
    // while the count is nonzero. RESULT is loaded only when leaving SHIFT,
    // so intermediate values never appear on it. The counter stops at zero
    // and never wraps.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            work   <= '0;
            op     <= '0;
            count  <= '0;
            RESULT <= '0;
        end else if (accept) begin
            work  <= DATA_IN;
            op    <= SHIFT_OP;
            count <= eff_count;
        end else if (state == ST_SHIFT) begin
            if (count == '0) begin
                RESULT <= work;
            end else begin
                work  <= work_step;
                count <= count - 1'b1;
            end
        end
    end

    // Status outputs decode directly from the state.
    assign BUSY = (state == ST_SHIFT);
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed bench for shift_sequencer. Each issued operation pushes its
// expected result and the cycle at which DONE should appear. A monitor
// process pops and compares whenever DONE is seen.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] DATA_IN;
    logic [7:0] SHIFT_AMT;
    logic [1:0] SHIFT_OP;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    typedef struct {
        logic [7:0] res;
        int         cyc;
        string      name;
    } exp_t;

    exp_t expQ[$];
    int   cyc;
    int   checks;
    int   errors;

    shift_sequencer #(.WIDTH(8), .AMT_WIDTH(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .DATA_IN  (DATA_IN),
        .SHIFT_AMT(SHIFT_AMT),
        .SHIFT_OP (SHIFT_OP),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT)
    );

    // Free-running clock and an edge counter used to time DONE arrivals.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request starting at a falling edge. The next rising edge is E0.
    // When expectDone is set, the bench pushes the result and the DONE cycle
    // it computed by hand.
    task automatic applyStimulus(input logic [1:0] opv, input logic [7:0] data,
                                 input logic [7:0] amt, input bit expectDone,
                                 input logic [7:0] expRes, input int n,
                                 input string name);
        exp_t e;
        SHIFT_OP  = opv;
        DATA_IN   = data;
        SHIFT_AMT = amt;
        START     = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (expectDone) begin
            e.res  = expRes;
            e.cyc  = cyc + n + 1;
            e.name = name;
            expQ.push_back(e);
        end
    endtask

    // Wait on falling edges for DONE, with a cycle budget. BUSY must be low
    // in the DONE cycle.
    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) checkOutput({name, "_busy_in_done"}, 32'(BUSY), 32'd0);
    endtask

    // Scoreboard monitor. Any DONE without a pending expectation is an error.
    always @(negedge CLK) begin
        if (!RESET && DONE) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, "_result"}, 32'(RESULT), 32'(e.res));
                checkOutput({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        RESET     = 1'b1;
        START     = 1'b0;
        DATA_IN   = 8'h00;
        SHIFT_AMT = 8'h00;
        SHIFT_OP  = 2'b00;
        repeat (2) @(negedge CLK);
        checkOutput("reset_busy", 32'(BUSY), 32'd0);
        checkOutput("reset_done", 32'(DONE), 32'd0);
        checkOutput("reset_result", 32'(RESULT), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // sra 0x96 by 2 -> 0xE5. BUSY must be high right after acceptance.
        applyStimulus(2'b10, 8'h96, 8'd2, 1'b1, 8'hE5, 2, "sra2");
        @(negedge CLK);
        checkOutput("sra2_busy", 32'(BUSY), 32'd1);
        checkOutput("sra2_no_early_result", 32'(RESULT), 32'd0);
        waitDone("sra2");
        repeat (7) @(negedge CLK);
        checkOutput("sra2_hold_result", 32'(RESULT), 32'hE5);
        checkOutput("sra2_hold_done_low", 32'(DONE), 32'd0);

        applyStimulus(2'b01, 8'h96, 8'd2, 1'b1, 8'h25, 2, "srl2");
        waitDone("srl2");
        @(negedge CLK);
        applyStimulus(2'b00, 8'h96, 8'd3, 1'b1, 8'hB0, 3, "sll3");
        waitDone("sll3");
        @(negedge CLK);
        applyStimulus(2'b11, 8'h96, 8'd3, 1'b1, 8'hD2, 3, "ror3");
        waitDone("ror3");
        @(negedge CLK);
        applyStimulus(2'b11, 8'h96, 8'd8, 1'b1, 8'h96, 0, "ror8");
        waitDone("ror8");
        @(negedge CLK);
        applyStimulus(2'b11, 8'h96, 8'd11, 1'b1, 8'hD2, 3, "ror11");
        waitDone("ror11");
        @(negedge CLK);
        applyStimulus(2'b00, 8'h5A, 8'd0, 1'b1, 8'h5A, 0, "sll0");
        waitDone("sll0");
        @(negedge CLK);
        applyStimulus(2'b10, 8'h80, 8'd200, 1'b1, 8'hFF, 8, "sra200");
        waitDone("sra200");
        @(negedge CLK);
        applyStimulus(2'b01, 8'hFF, 8'd255, 1'b1, 8'h00, 8, "srl255");
        waitDone("srl255");
        @(negedge CLK);

        // A START pulse during SHIFT, with different operands that stay
        // applied, must be ignored.
        applyStimulus(2'b00, 8'h96, 8'd3, 1'b1, 8'hB0, 3, "ignore");
        @(negedge CLK);
        SHIFT_OP  = 2'b11;
        DATA_IN   = 8'h3C;
        SHIFT_AMT = 8'd1;
        START     = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        waitDone("ignore");

        // Back-to-back: request issued in the DONE cycle.
        applyStimulus(2'b00, 8'h01, 8'd1, 1'b1, 8'h02, 1, "b2b");
        waitDone("b2b");
        @(negedge CLK);

        // Reset mid-operation, after E2. The aborted op must never finish.
        applyStimulus(2'b10, 8'h96, 8'd5, 1'b0, 8'h00, 5, "abort");
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(BUSY), 32'd0);
        checkOutput("abort_done", 32'(DONE), 32'd0);
        checkOutput("abort_result", 32'(RESULT), 32'd0);
        @(negedge CLK);
        // START during reset must be ignored.
        SHIFT_OP  = 2'b00;
        DATA_IN   = 8'h01;
        SHIFT_AMT = 8'd0;
        START     = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        RESET = 1'b0;
        repeat (12) @(negedge CLK);
        checkOutput("abort_idle_busy", 32'(BUSY), 32'd0);
        checkOutput("abort_idle_result", 32'(RESULT), 32'd0);

        applyStimulus(2'b10, 8'h96, 8'd2, 1'b1, 8'hE5, 2, "post_reset");
        waitDone("post_reset");
        repeat (3) @(negedge CLK);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift/rotate controller for the 8-bit processor ALU path. It accepts an operand, a shift amount and an operation code, then shifts one bit position per clock. The fill bit is chosen per operation: 0 for logical, the current MSB for arithmetic, the LSB for rotate. It presents the result with a one-cycle DONE pulse, and the CPU control unit stalls on BUSY.

Parameters:
WIDTH, 8, operand/result width in bits
AMT_WIDTH, 8, width of the shift-amount input

Ports:
CLK  input  1  system clock, rising-edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request; sampled on the rising edge while the block is in IDLE or DONE state
DATA_IN  input  WIDTH  operand, captured on the edge that accepts START
SHIFT_AMT  input  AMT_WIDTH  shift amount, captured with START
SHIFT_OP  input  2  00 = sll, 01 = srl, 10 = sra, 11 = ror; captured with START
BUSY  output  1  high while an accepted operation is in progress
DONE  output  1  one-cycle pulse: RESULT is valid
RESULT  output  WIDTH  shifted value; held stable from DONE until the next START is accepted

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: state = IDLE; BUSY = 0; DONE = 0; RESULT = 0; internal count, operand and op registers = 0.
- States:
  - IDLE: wait for START.
  - SHIFT: perform one shift per clock.
  - DONE: DONE = 1 for exactly one cycle, then go to IDLE.
- Accepting START:
  - START is accepted in IDLE and in DONE; back-to-back operations are allowed.
  - START is ignored while in SHIFT, with no effect on the captured operands.
- Effective count n, computed at acceptance:
  - sll/srl/sra: n = min(SHIFT_AMT, WIDTH).
  - ror: n = SHIFT_AMT mod WIDTH.
- Timing, with E0 = the edge that accepts START:
  - n = 0: go straight to DONE at E1. RESULT = DATA_IN. BUSY is high only for the E0–E1 cycle.
  - n > 0: the working register shifts once at each of edges E1..En. DONE rises at E(n+1).
  - BUSY is high from E0 until E(n+1) and low in the DONE cycle.
  - Total latency from START to DONE = n+1 cycles.
- Per-step operation (working register W):
  - sll: W = {W[WIDTH-2:0], 0}.
  - srl: W = {0, W[WIDTH-1:1]}.
  - sra: W = {W[WIDTH-1], W[WIDTH-1:1]}. The fill bit is recomputed from the current MSB at every step.
  - ror: W = {W[0], W[WIDTH-1:1]}.
- RESULT update: loaded from W on the edge entering DONE. It is not updated during SHIFT; intermediate values must not appear on RESULT.
- Saturation: amounts ≥ WIDTH for sll/srl/sra give all-fill results (0x00, or 0x00/0xFF for sra depending on sign) after exactly WIDTH steps.
- Counter: decrements per step and never wraps below 0.
- RESET mid-operation: immediate return to IDLE with all outputs cleared. No DONE is generated for the aborted operation.
- START coincident with RESET: reset wins.
- SHIFT_OP/DATA_IN/SHIFT_AMT changing during SHIFT: no effect.

Test Plan:
- Arithmetic shift: reset, then START with sra, 0x96, amt 2 → BUSY high E0–E3, DONE pulse at E3, RESULT = 0xE5; RESULT still 0xE5 at E10.
- Logical shifts: srl 0x96 amt 2 → RESULT 0x25, DONE at E3. sll 0x96 amt 3 → RESULT 0xB0, DONE at E4.
- Rotate: ror 0x96 amt 3 → 0xD2, DONE at E4. ror 0x96 amt 8 → n = 0, DONE at E1, RESULT 0x96.
- Saturation: sra 0x80 amt 200 → DONE at E9, RESULT 0xFF. srl 0xFF amt 255 → DONE at E9, RESULT 0x00.
- Handshake: START pulsed during SHIFT with different operands → ignored, first result correct. START asserted in the DONE cycle (sll 0x01 amt 1) → accepted, next DONE 2 cycles later, RESULT 0x02.
- Reset mid-operation: sra 0x96 amt 5, assert RESET asynchronously mid-cycle after E2 → BUSY, DONE, RESULT immediately 0, no DONE pulse; a new START after release operates normally.
